// File: rtl/lcd_fetch.sv
// LCD scan/fetch engine: steals one VRAM slot in six from the DMA and turns
// 2bpp VRAM bytes into a 160x160 pixel stream with coarse/fine scroll.
module lcd_fetch #(
  parameter int LINES_TOTAL = 170,
  parameter int ROW_STRIDE  = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [5:0]  AB,
  input  logic        cpu_rnw,
  input  logic        lcd_cs,
  input  logic [7:0]  data_in,
  input  logic [7:0]  vram_data,
  output logic [12:0] vram_addr,
  output logic        lcd_en,
  output logic        pix_valid,
  output logic [1:0]  pixel,
  output logic [7:0]  line,
  output logic        vblank,
  output logic        frame_start
);

  localparam logic [7:0]  VIS_LINES = 8'd160;
  localparam logic [7:0]  LAST_LINE = 8'(LINES_TOTAL - 1);
  localparam logic [5:0]  LAST_SLOT = 6'd47;
  localparam logic [5:0]  LAST_FETCH = 6'd40;
  localparam logic [12:0] STRIDE13  = 13'(ROW_STRIDE);

  logic [2:0]  r_div;
  logic [5:0]  r_sc;
  logic [7:0]  r_line;
  logic [12:0] r_row_base;
  logic [7:0]  r_xs_line;
  logic [7:0]  r_xscroll;
  logic [7:0]  r_yscroll;
  logic [7:0]  r_sr;
  logic        r_fetched;
  logic [12:0] r_vram_addr;
  logic        r_pix_valid;
  logic [1:0]  r_pixel;
  logic        r_frame_start;

  logic        w_div_wrap, w_sc_wrap, w_line_wrap;
  logic [2:0]  w_div_next;
  logic [5:0]  w_sc_next;
  logic [7:0]  w_line_next;
  logic [7:0]  w_xs_next;
  logic [12:0] w_row_next;
  logic [12:0] w_ybase;
  logic [12:0] w_addr_next;
  logic        w_emit;
  logic [1:0]  w_p;
  logic [7:0]  w_t;
  logic [7:0]  w_fine;
  logic        w_in_range;
  logic        w_reg_wr;

  always_comb begin
    w_div_wrap  = (r_div == 3'd5);
    w_sc_wrap   = w_div_wrap && (r_sc == LAST_SLOT);
    w_line_wrap = w_sc_wrap && (r_line == LAST_LINE);

    w_div_next  = w_div_wrap ? 3'd0 : r_div + 3'd1;
    w_sc_next   = r_sc;
    if (w_div_wrap)
      w_sc_next = (r_sc == LAST_SLOT) ? 6'd0 : r_sc + 6'd1;
    w_line_next = r_line;
    if (w_sc_wrap)
      w_line_next = w_line_wrap ? 8'd0 : r_line + 8'd1;

    // Scroll values are only sampled at line/frame boundaries.
    w_xs_next  = w_sc_wrap ? r_xscroll : r_xs_line;
    w_ybase    = {5'd0, r_yscroll} * STRIDE13;
    w_row_next = r_row_base;
    if (w_line_wrap)
      w_row_next = w_ybase;
    else if (w_sc_wrap)
      w_row_next = r_row_base + STRIDE13;

    w_addr_next = w_row_next + {7'd0, w_xs_next[7:2]} + {7'd0, w_sc_next};

    // Byte k was fetched in slot k and is shifted out in slot k+1, div 1..4.
    w_emit     = r_fetched && (r_div >= 3'd1) && (r_div <= 3'd4);
    w_p        = r_div[1:0] - 2'd1;
    w_t        = {r_sc - 6'd1, 2'b00} + {6'd0, w_p};
    w_fine     = {6'd0, r_xs_line[1:0]};
    w_in_range = (w_t >= w_fine) && (w_t <= 8'd159 + w_fine);

    w_reg_wr   = lcd_cs && !cpu_rnw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div         <= '0;
      r_sc          <= '0;
      r_line        <= '0;
      r_row_base    <= '0;
      r_xs_line     <= '0;
      r_xscroll     <= '0;
      r_yscroll     <= '0;
      r_sr          <= '0;
      r_fetched     <= 1'b0;
      r_vram_addr   <= '0;
      r_pix_valid   <= 1'b0;
      r_pixel       <= '0;
      r_frame_start <= 1'b0;
    end else if (ce) begin
      r_div       <= w_div_next;
      r_sc        <= w_sc_next;
      r_line      <= w_line_next;
      r_row_base  <= w_row_next;
      r_xs_line   <= w_xs_next;
      r_vram_addr <= w_addr_next;
      if (w_div_wrap)
        r_fetched <= lcd_en;
      if (w_reg_wr && AB == 6'h02)
        r_xscroll <= data_in;
      if (w_reg_wr && AB == 6'h03)
        r_yscroll <= data_in;
      if (r_fetched && r_div == 3'd0)
        r_sr <= vram_data;
      else if (w_emit)
        r_sr <= {2'b00, r_sr[7:2]};
      if (w_emit)
        r_pixel <= r_sr[1:0];
      r_pix_valid   <= w_emit && w_in_range;
      r_frame_start <= w_line_wrap;
    end else begin
      r_pix_valid   <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign lcd_en      = (r_sc <= LAST_FETCH) && (r_line < VIS_LINES);
  assign vram_addr   = r_vram_addr;
  assign pix_valid   = r_pix_valid;
  assign pixel       = r_pixel;
  assign line        = r_line;
  assign vblank      = (r_line >= VIS_LINES);
  assign frame_start = r_frame_start;

endmodule

// File: doc/lcd_fetch.md
Name: lcd_fetch

Overview:
- LCD scan/fetch engine. Consumes VRAM bandwidth left by the DMA controller and converts 2bpp VRAM bytes into a 160x160 pixel stream.
- Owns the LCD slot: drives `lcd_en` to the DMA so that the DMA yields the VRAM bus on every 6th `ce` while a fetch is due.
- Its 6-phase divider is lock-stepped with the DMA divider: both reset to 0 and both advance on `ce`.

Parameters:
- LINES_TOTAL, 170, lines per frame including vblank (lines 160..LINES_TOTAL-1 are blank).
- ROW_STRIDE, 48, VRAM bytes per row.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ce  in  1  clock enable; all state advances only when ce=1
- AB  in  6  CPU register address
- cpu_rnw  in  1  CPU read/not-write
- lcd_cs  in  1  LCD register block select
- data_in  in  8  CPU write data
- vram_data  in  8  VRAM read data, valid on the ce following the fetch slot
- vram_addr  out  13  VRAM fetch address
- lcd_en  out  1  fetch due this slot (to DMA)
- pix_valid  out  1  pixel strobe, one ce wide
- pixel  out  2  pixel value
- line  out  8  current line, 0..LINES_TOTAL-1
- vblank  out  1  high when line>=160
- frame_start  out  1  one-ce pulse at line 0, slot 0, div 0

Behaviour:
- Counters:
  - div: 0..5, +1 per ce, wraps 5->0.
  - sc (slot): 0..47, +1 when div==5 on ce.
  - line: +1 when sc wraps 47->0; wraps LINES_TOTAL-1->0.
- `lcd_en` = (sc<=40) && (line<160), combinational from registered counters. A fetch occurs on the ce with div==5 and lcd_en=1.
- Registers: on ce & ~cpu_rnw & lcd_cs:
  - AB=0x02 writes xscroll.
  - AB=0x03 writes yscroll.
  - All other AB values are ignored.
- Scroll sampling:
  - xscroll is copied to xs_line when sc wraps to 0, i.e. at line start.
  - yscroll is used to load row_base at frame start. A mid-line or mid-frame write takes effect at the next boundary.
- Address generation:
  - row_base = yscroll*ROW_STRIDE (mod 8192) at frame start; row_base += ROW_STRIDE (mod 8192) at each line start.
  - vram_addr = row_base + xs_line[7:2] + sc, 13-bit wrap. Registered; stable throughout the slot.
- Data capture: on the ce with div==0 following a fetch, shift register sr <= vram_data.
- Pixel emission:
  - On div=1,2,3,4 of a slot whose preceding slot fetched: pixel = sr[1:0], then sr >>= 2 (LSB pixel is leftmost).
  - Global index px = 4*k + p - xs_line[1:0], where k = byte index 0..40 and p = 0..3.
  - pix_valid=1 only when 0<=px<=159. Exactly 160 strobes per visible line for any fine scroll. Pixels outside that range are discarded with pix_valid=0.
- Vblank: no fetch, no pix_valid, vblank=1.
- frame_start: asserted on the ce where line=0, sc=0, div=0.
- Reset (any cycle, including mid-line):
  - div, sc, line, row_base, xs_line, xscroll, yscroll, sr all cleared to 0.
  - pix_valid=0, pixel=0, frame_start=0, vram_addr=0.
  - lcd_en=1 immediately after reset, since line 0 slot 0 is a fetch slot.
- ce=0: all state and outputs hold; pix_valid and frame_start hold 0.

Test Plan:
- Reset, xscroll=yscroll=0, VRAM[n]=n:
  - Line 0 vram_addr sequence is 0,1,...,40.
  - First 4 pixels are 0,0,0,0; pixels 4..7 are 1,0,0,0.
  - 160 pix_valid per line.
  - Line 1 starts at address 48.
- Divider alignment: count ce over one line -> lcd_en high for 41 slots and low for 7. Fetches occur only on div==5; 288 ce per line.
- xscroll=0x05 written mid-line 3:
  - Line 3 is unchanged.
  - Line 4 first fetch address is 4*48+1.
  - The first emitted pixel is bit pair [3:2] of that byte.
  - Still exactly 160 strobes.
- yscroll=170 (row base 8160): next frame line 0 addresses run 8160..8191, then wrap to 0..8.
- Full frame -> vblank rises at line 160 with no fetches or strobes. frame_start pulses once per LINES_TOTAL*288 ce.
- Reset asserted at line 50 slot 20 -> next ce: line=0, sc=0, div=0, scroll registers 0, lcd_en=1, no spurious pix_valid.
